imm_encoder: RTL and testbench

//  Inverse of the immediate extender: takes a 32-bit constant/offset plus an ImmSrc class.

---
 rtl/imm_encoder.sv | 140 ++++++++++++++
 tb/tb_imm_encoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Immediate encoder: maps a 32-bit constant/offset to a 24-bit instruction immediate field.
// DP rotated immediates use an iterative search testing ROTS_PER_CYCLE rotations per cycle.
module imm_encoder #(
    parameter int unsigned ROTS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    input  logic [1:0]  imm_src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] imm_field,
    output logic        encodable
);

    localparam int unsigned NGRP     = 16 / ROTS_PER_CYCLE;
    localparam logic [3:0]  LAST_GRP = 4'(NGRP - 1);

    localparam logic [1:0] SRC_DP  = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_B   = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] value_q, value_d;
    logic [3:0]  grp_q, grp_d;
    logic [23:0] field_q, field_d;
    logic        enc_q, enc_d;

    logic        hit;
    logic [3:0]  hit_k;
    logic [7:0]  hit_imm8;
    logic        mem_ok;
    logic        b_ok;

    assign in_ready  = reset_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign imm_field = field_q;
    assign encodable = enc_q;

    assign mem_ok = (value[31:12] == 20'd0);
    // Branch offset must be word aligned and fit a signed 26-bit byte range.
    assign b_ok   = (value[1:0] == 2'b00) && ((&value[31:25]) || !(|value[31:25]));

    // Test every rotation of the current group; the lowest k in the group wins.
    always_comb begin
        hit      = 1'b0;
        hit_k    = 4'd0;
        hit_imm8 = 8'd0;
        for (int unsigned j = 0; j < ROTS_PER_CYCLE; j++) begin
            logic [3:0]  k;
            logic [63:0] dbl;
            logic [31:0] rot;
            k   = 4'(int'(grp_q) * ROTS_PER_CYCLE + j);
            dbl = {value_q, value_q} << {k, 1'b0};
            rot = dbl[63:32];
            if (!hit && (rot[31:8] == 24'd0)) begin
                hit      = 1'b1;
                hit_k    = k;
                hit_imm8 = rot[7:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        grp_d   = grp_q;
        field_d = field_q;
        enc_d   = enc_q;
        case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    value_d = value;
                    grp_d   = 4'd0;
                    field_d = 24'd0;
                    enc_d   = 1'b0;
                    state_d = StDone;
                    unique case (imm_src)
                        SRC_DP: state_d = StSearch;
                        SRC_MEM: begin
                            if (mem_ok) begin
                                enc_d   = 1'b1;
                                field_d = {12'd0, value[11:0]};
                            end
                        end
                        SRC_B: begin
                            if (b_ok) begin
                                enc_d   = 1'b1;
                                field_d = value[25:2];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StSearch: begin
                if (hit) begin
                    enc_d   = 1'b1;
                    field_d = {12'd0, hit_k, hit_imm8};
                    state_d = StDone;
                end else if (grp_q == LAST_GRP) begin
                    enc_d   = 1'b0;
                    field_d = 24'd0;
                    state_d = StDone;
                end else begin
                    grp_d = grp_q + 4'd1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            value_q <= 32'd0;
            grp_q   <= 4'd0;
            field_q <= 24'd0;
            enc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            grp_q   <= grp_d;
            field_q <= field_d;
            enc_q   <= enc_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: driver pushes expected results, monitor checks each output.
module tb_imm_encoder;

    localparam int unsigned R    = 1;
    localparam int          NGRP = 16 / R;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] value = 32'd0;
    logic [1:0]  imm_src = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] imm_field;
    logic        encodable;

    imm_encoder #(.ROTS_PER_CYCLE(R)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .imm_src   (imm_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_field (imm_field),
        .encodable (encodable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] field;
        logic        enc;
        int          lat;
        int          drv_cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic over the encoding rules.
    function automatic void model(input logic [31:0] v, input logic [1:0] src,
                                  output logic [23:0] f, output logic e, output int lat);
        longint unsigned x;
        logic [31:0]     rot;
        int              sv;
        bit              found;
        f = 24'd0;
        e = 1'b0;
        lat = 1;
        case (src)
            2'b00: begin
                found = 1'b0;
                lat = 1 + NGRP;
                for (int k = 0; k < 16; k++) begin
                    x = {32'd0, v};
                    x = x << (2 * k);
                    rot = x[31:0] | x[63:32];
                    if (!found && rot < 256) begin
                        found = 1'b1;
                        e = 1'b1;
                        f = {12'd0, 4'(k), rot[7:0]};
                        lat = 2 + k / int'(R);
                    end
                end
            end
            2'b01: begin
                if (v < 32'd4096) begin
                    e = 1'b1;
                    f = v[23:0];
                end
            end
            2'b10: begin
                sv = $signed(v);
                if ((v % 4 == 0) && sv >= -33554432 && sv <= 33554428) begin
                    e = 1'b1;
                    f = 24'(sv >>> 2);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic send(input logic [31:0] v, input logic [1:0] s, input logic [23:0] f,
                        input logic e, input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            in_valid = 1'b1;
            value = v;
            imm_src = s;
            if (push) q.push_back('{f, e, lat, cyc});
            @(negedge clk);
            in_valid = 1'b0;
            value = $urandom;
            imm_src = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic send_model(input logic [31:0] v, input logic [1:0] s);
        logic [23:0] f;
        logic        e;
        int          lat;
        model(v, s, f, e, lat);
        send(v, s, f, e, lat, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    // Consumer back-pressure, changed just after the edge so the monitor sees it stable.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares held outputs against the head of the scoreboard every cycle.
    initial begin
        bit   first = 1'b1;
        bit   want_ready = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                first = 1'b1;
                want_ready = 1'b0;
            end else begin
                if (want_ready) begin
                    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
                    want_ready = 1'b0;
                end
                if (out_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                    end else begin
                        e = q[0];
                        if (first) begin
                            check("latency", cyc - e.drv_cyc, e.lat);
                            first = 1'b0;
                        end
                        check("imm_field", {8'd0, imm_field}, {8'd0, e.field});
                        check("encodable", {31'd0, encodable}, {31'd0, e.enc});
                        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
                        if (out_ready) begin
                            void'(q.pop_front());
                            first = 1'b1;
                            want_ready = 1'b1;
                        end
                    end
                end
            end
        end
    end

    typedef struct {
        logic [1:0]  src;
        logic [31:0] v;
        logic [23:0] f;
        logic        e;
        int          lat;
    } vec_t;

    vec_t dir[13] = '{
        '{2'b00, 32'h0000_00FF, 24'h0000FF, 1'b1, 2},
        '{2'b00, 32'hFF00_0000, 24'h0004FF, 1'b1, 6},
        '{2'b00, 32'h0000_03FC, 24'h000FFF, 1'b1, 17},
        '{2'b00, 32'hF000_000F, 24'h0002FF, 1'b1, 4},
        '{2'b00, 32'h0000_0101, 24'h000000, 1'b0, 17},
        '{2'b00, 32'h0000_0000, 24'h000000, 1'b1, 2},
        '{2'b01, 32'h0000_0ABC, 24'h000ABC, 1'b1, 1},
        '{2'b01, 32'h0000_1000, 24'h000000, 1'b0, 1},
        '{2'b11, 32'h1234_5678, 24'h000000, 1'b0, 1},
        '{2'b10, 32'hFFFF_FFF8, 24'hFFFFFE, 1'b1, 1},
        '{2'b10, 32'h01FF_FFFC, 24'h7FFFFF, 1'b1, 1},
        '{2'b10, 32'h0000_0006, 24'h000000, 1'b0, 1},
        '{2'b10, 32'h0200_0000, 24'h000000, 1'b0, 1}
    };

    initial begin
        logic [31:0]     v;
        logic [1:0]      s;
        longint unsigned x;
        int              n;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_imm_field", {8'd0, imm_field}, 32'd0);
        check("rst_encodable", {31'd0, encodable}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        foreach (dir[i]) send(dir[i].v, dir[i].src, dir[i].f, dir[i].e, dir[i].lat, 1'b1);
        drain();

        // Held result under back-pressure.
        stall = 1'b1;
        send(32'hFF00_0000, 2'b00, 24'h0004FF, 1'b1, 6, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (3) @(negedge clk);
        stall = 1'b0;
        drain();

        // Reset in the middle of a DP search aborts it.
        send(32'h0000_0101, 2'b00, 24'd0, 1'b0, 0, 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
            check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        end
        check("postrst_encodable", {31'd0, encodable}, 32'd0);
        send(32'h0000_00FF, 2'b00, 24'h0000FF, 1'b1, 2, 1'b1);
        drain();

        // Randomized traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            s = 2'($urandom_range(0, 3));
            v = $urandom;
            case (s)
                2'b00: begin
                    if ($urandom_range(0, 3) != 0) begin
                        x = {24'd0, 8'($urandom_range(0, 255)), 32'd0};
                        x = x >> (2 * $urandom_range(0, 15));
                        v = x[63:32] | x[31:0];
                    end
                end
                2'b01: if ($urandom_range(0, 1) == 1) v = 32'($urandom_range(0, 8191));
                2'b10: begin
                    if ($urandom_range(0, 2) != 0) v = {{7{v[25]}}, v[24:0]};
                    if ($urandom_range(0, 2) != 0) v[1:0] = 2'b00;
                end
                default: ;
            endcase
            send_model(v, s);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
